// File: rtl/reset_sequencer.sv
// Ordered reset-release sequencer: holds every stage in reset, then frees them one at a time as each ready arrives.
// Optional stage timeout and ERROR state are built only when ACX_RESET_SEQ_TIMEOUT_EN is defined.
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 64,
  parameter int STAGE_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_restart,
  input  logic [NUM_STAGES-1:0] i_stage_ready,
  output logic [NUM_STAGES-1:0] o_stage_rstn,
  output logic                  o_done,
  output logic                  o_error,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] o_err_stage
);

  localparam int KW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
  localparam int MAX_P  = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
`else
  localparam int MAX_P  = MAX_HG;
`endif
  localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P + 1) : 1;

  localparam logic [KW-1:0] LAST_K    = KW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_WAIT  = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   stage_rstn_q, stage_rstn_d;
  logic                    done_q, done_d;
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
  logic                    error_q, error_d;
  logic [KW-1:0]           err_stage_q, err_stage_d;
`endif

  logic [KW-1:0]           k_nxt;
  logic [CW-1:0]           cnt_inc;
  logic                    ready_k;

  always_comb begin
    k_nxt   = k_q + KW'(1);
    // Saturating so a counter can never wrap back into range.
    cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    ready_k = i_stage_ready[k_q];
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    stage_rstn_d = stage_rstn_q;
    done_d       = done_q;
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
    error_d      = error_q;
    err_stage_d  = err_stage_q;
`endif
    if (i_restart) begin
      state_d      = S_HOLD;
      k_d          = '0;
      cnt_d        = '0;
      stage_rstn_d = '0;
      done_d       = 1'b0;
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
      error_d      = 1'b0;
      err_stage_d  = '0;
`endif
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q >= HOLD_LAST) begin
            stage_rstn_d[0] = 1'b1;
            k_d             = '0;
            cnt_d           = '0;
            state_d         = S_WAIT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT: begin
          if (ready_k) begin
            cnt_d = '0;
            if (k_q == LAST_K) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (STAGE_GAP == 0) begin
              // Zero gap: next stage leaves reset on the same edge its predecessor is seen ready.
              stage_rstn_d[k_nxt] = 1'b1;
              k_d                 = k_nxt;
            end else begin
              state_d = S_GAP;
            end
          end
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
          else if (cnt_q >= TMO_LIMIT) begin
            stage_rstn_d[k_q] = 1'b0;
            error_d           = 1'b1;
            err_stage_d       = k_q;
            state_d           = S_ERROR;
          end else begin
            cnt_d = cnt_inc;
          end
`endif
        end
        S_GAP: begin
          if (cnt_q >= GAP_LAST) begin
            stage_rstn_d[k_nxt] = 1'b1;
            k_d                 = k_nxt;
            cnt_d               = '0;
            state_d             = S_WAIT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DONE:  state_d = S_DONE;
        S_ERROR: state_d = S_ERROR;
        default: begin
          state_d      = S_HOLD;
          k_d          = '0;
          cnt_d        = '0;
          stage_rstn_d = '0;
          done_d       = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= S_HOLD;
      k_q          <= '0;
      cnt_q        <= '0;
      stage_rstn_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      stage_rstn_q <= stage_rstn_d;
      done_q       <= done_d;
    end
  end

`ifdef ACX_RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      error_q     <= 1'b0;
      err_stage_q <= '0;
    end else begin
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign o_error     = error_q;
  assign o_err_stage = err_stage_q;
`else
  assign o_error     = 1'b0;
  assign o_err_stage = '0;
`endif

  assign o_stage_rstn = stage_rstn_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected outputs are queued per checkpoint and compared when reached.
// Instance A uses a 16-cycle gap and 100-cycle timeout; instance B uses a zero gap with all readies high.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, restart_a, restart_b;
  logic [3:0] rdy_a, rdy_b;
  logic [3:0] srst_a, srst_b;
  logic       done_a, done_b, err_a, err_b;
  logic [1:0] es_a, es_b;

  reset_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(64), .STAGE_GAP(16), .TIMEOUT_CYCLES(100)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_restart(restart_a), .i_stage_ready(rdy_a),
    .o_stage_rstn(srst_a), .o_done(done_a), .o_error(err_a), .o_err_stage(es_a));

  reset_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(64), .STAGE_GAP(0), .TIMEOUT_CYCLES(100)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_restart(restart_b), .i_stage_ready(rdy_b),
    .o_stage_rstn(srst_b), .o_done(done_b), .o_error(err_b), .o_err_stage(es_b));

  typedef struct packed {
    logic       inst;
    logic [3:0] rstn;
    logic       done;
    logic       err;
    logic [1:0] es;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    total = 0;
  int    bad   = 0;
  int    ecnt  = 0;

  function automatic logic [3:0] m(input int n);
    m = 4'((1 << n) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic adv_to(input int e);
    while (ecnt < e) tick();
  endtask

  task automatic push(input string tag, input logic inst, input logic [3:0] r,
                      input logic d, input logic e, input logic [1:0] es);
    exp_t x;
    x.inst = inst; x.rstn = r; x.done = d; x.err = e; x.es = es;
    sbq.push_back(x);
    tagq.push_back(tag);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [3:0] o, input logic [3:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s %s observed=%h expected=%h at edge %0d", tag, fld, o, e, ecnt);
    end
  endtask

  task automatic drain();
    exp_t       x;
    string      t;
    logic [3:0] o_r;
    logic       o_d, o_e;
    logic [1:0] o_s;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      t = tagq.pop_front();
      o_r = x.inst ? srst_b : srst_a;
      o_d = x.inst ? done_b : done_a;
      o_e = x.inst ? err_b  : err_a;
      o_s = x.inst ? es_b   : es_a;
      cmp(t, "stage_rstn", o_r, x.rstn);
      cmp(t, "done", {3'b0, o_d}, {3'b0, x.done});
      cmp(t, "error", {3'b0, o_e}, {3'b0, x.err});
      cmp(t, "err_stage", {2'b0, o_s}, {2'b0, x.es});
    end
  endtask

  // Called right after rstn release with ecnt = 0 and rdy_a cleared.
  task automatic nominal(input string pfx);
    int rel, r;
    push({pfx, "_a_hold63"}, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    push({pfx, "_b_hold63"}, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0);
    adv_to(63); drain();
    push({pfx, "_a_rel0"}, 1'b0, 4'h1, 1'b0, 1'b0, 2'd0);
    push({pfx, "_b_rel0"}, 1'b1, 4'h1, 1'b0, 1'b0, 2'd0);
    adv_to(64); drain();
    for (int e = 65; e <= 68; e++) begin
      push({pfx, "_b_gap0"}, 1'b1, (e <= 67) ? m(e - 63) : 4'hF, (e == 68), 1'b0, 2'd0);
      adv_to(e); drain();
    end
    rel = 64;
    for (int s = 0; s < 4; s++) begin
      adv_to(rel + 5);
      r = rel + 6;
      if (s == 3) begin
        push({pfx, "_a_predone"}, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0);
        drain();
      end
      rdy_a[s] = 1'b1;
      if (s < 3) begin
        push({pfx, "_a_gap_pre"}, 1'b0, m(s + 1), 1'b0, 1'b0, 2'd0);
        adv_to(r + 15); drain();
        push({pfx, "_a_gap_rel"}, 1'b0, m(s + 2), 1'b0, 1'b0, 2'd0);
        adv_to(r + 16); drain();
        rel = r + 16;
      end else begin
        push({pfx, "_a_done"}, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0);
        adv_to(r); drain();
      end
    end
  endtask

  initial begin
    int t, t2, rel0, rel1, rel2;
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
    int t3;
`endif
    rstn = 1'b0; restart_a = 1'b0; restart_b = 1'b0;
    rdy_a = 4'h0; rdy_b = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    push("a_por", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    push("b_por", 1'b1, 4'h0, 1'b0, 1'b0, 2'd0);
    drain();
    rstn = 1'b1; ecnt = 0;
    nominal("run1");

    // Asynchronous reset while in DONE, mid-cycle.
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    push("a_async", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    push("b_async", 1'b1, 4'h0, 1'b0, 1'b0, 2'd0);
    drain();
    @(posedge clk);
    #1;
    rdy_a = 4'h0; rstn = 1'b1; ecnt = 0;
    nominal("run2");

    // Restart from DONE, then again while in GAP after stage 1.
    rdy_a = 4'h0; restart_a = 1'b1;
    tick();
    restart_a = 1'b0; t = ecnt;
    push("a_rst_done", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    drain();
    push("a_rh_pre", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    adv_to(t + 63); drain();
    push("a_rh_rel", 1'b0, 4'h1, 1'b0, 1'b0, 2'd0);
    adv_to(t + 64); drain();
    rel0 = t + 64;
    adv_to(rel0 + 5); rdy_a[0] = 1'b1;
    rel1 = rel0 + 22;
    push("a_rh_rel1", 1'b0, 4'h3, 1'b0, 1'b0, 2'd0);
    adv_to(rel1); drain();
    adv_to(rel1 + 5); rdy_a[1] = 1'b1;
    push("a_in_gap", 1'b0, 4'h3, 1'b0, 1'b0, 2'd0);
    adv_to(rel1 + 9); drain();
    restart_a = 1'b1; rdy_a = 4'h0;
    tick();
    restart_a = 1'b0; t2 = ecnt;
    push("a_rst_gap", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    drain();
    push("a_rg_pre", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    adv_to(t2 + 63); drain();
    push("a_rg_rel", 1'b0, 4'h1, 1'b0, 1'b0, 2'd0);
    adv_to(t2 + 64); drain();

    // Stage 2 ready never arrives.
    rel0 = t2 + 64;
    adv_to(rel0 + 5); rdy_a[0] = 1'b1;
    rel1 = rel0 + 22;
    adv_to(rel1 + 5); rdy_a[1] = 1'b1;
    rel2 = rel1 + 22;
    push("a_rel2", 1'b0, 4'h7, 1'b0, 1'b0, 2'd0);
    adv_to(rel2); drain();
`ifdef ACX_RESET_SEQ_TIMEOUT_EN
    push("a_tmo_pre", 1'b0, 4'h7, 1'b0, 1'b0, 2'd0);
    adv_to(rel2 + 100); drain();
    push("a_tmo", 1'b0, 4'h3, 1'b0, 1'b1, 2'd2);
    adv_to(rel2 + 101); drain();
    push("a_err_hold", 1'b0, 4'h3, 1'b0, 1'b1, 2'd2);
    adv_to(rel2 + 120); drain();
    restart_a = 1'b1; rdy_a = 4'h0;
    tick();
    restart_a = 1'b0; t3 = ecnt;
    push("a_err_clr", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    drain();
    push("a_rerun", 1'b0, 4'h1, 1'b0, 1'b0, 2'd0);
    adv_to(t3 + 64); drain();
`else
    push("a_no_tmo", 1'b0, 4'h7, 1'b0, 1'b0, 2'd0);
    adv_to(rel2 + 1000); drain();
`endif
    push("b_still_done", 1'b1, 4'hF, 1'b1, 1'b0, 2'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Ordered reset-release controller for the GDDR reference design. Takes one reset already synchronized by the reset processor into `i_clk` and releases up to `NUM_STAGES` downstream subsystem resets one at a time, e.g. NoC interface, then GDDR controller, then traffic generators. Before releasing the next stage it waits for the current stage's ready indication, such as GDDR training done, plus a programmable gap. It also supports a software-requested re-sequence.

## Interface
- `NUM_STAGES`, 4: number of sequenced reset outputs; range 1–16.
- `HOLD_CYCLES`, 64: cycles all outputs are held in reset before stage 0 is released; must be ≥1.
- `STAGE_GAP`, 16: cycles between the current stage's ready and the next stage's release; 0 is allowed.
- `TIMEOUT_CYCLES`, 65535: maximum cycles to wait for a stage's ready; must be ≥1. Used only with the timeout feature.
- `i_clk` input 1: single clock. All inputs are synchronous to it.
- `i_rstn` input 1: asynchronous, active-low reset. Deassertion is already synchronized to `i_clk` upstream.
- `i_restart` input 1: single-cycle request to re-run the whole sequence.
- `i_stage_ready` input `NUM_STAGES`: per-stage ready, active high, already synchronized to `i_clk`.
- `o_stage_rstn` output `NUM_STAGES`: per-stage active-low reset outputs, registered.
- `o_done` output 1: high while every stage is released and ready has been seen for every stage.
- `o_error` output 1: a stage timed out.
- `o_err_stage` output `$clog2(NUM_STAGES)`, minimum 1 bit: index of the stage that timed out.

## Operation
- States: HOLD, WAIT_RDY, GAP, DONE, ERROR. A stage index `k` selects the current stage.
- Reset values: `o_stage_rstn`=0, `o_done`=0, `o_error`=0, `o_err_stage`=0; state HOLD, `k`=0, counters 0.
- HOLD
  - Count `HOLD_CYCLES` cycles.
  - On the final count, set `o_stage_rstn[0]`=1 and go to WAIT_RDY with `k`=0.
- WAIT_RDY
  - Sample only `i_stage_ready[k]`; ready bits of other stages are ignored in every state.
  - If ready is seen and `k`=`NUM_STAGES`-1, go to DONE.
  - If ready is seen and `k` is not the last stage:
    - with `STAGE_GAP`=0, release stage `k`+1 on the same edge, increment `k` and stay in WAIT_RDY;
    - otherwise go to GAP.
- GAP
  - Count `STAGE_GAP` cycles.
  - On the final count, set `o_stage_rstn[k+1]`=1, increment `k` and go to WAIT_RDY.
- DONE
  - `o_done`=1. Hold this state indefinitely.
  - A ready bit dropping after it was seen has no effect.
- ERROR (timeout feature only)
  - `o_error`=1, `o_err_stage`=`k`.
  - `o_stage_rstn[k]` is driven back to 0; earlier stages stay released; later stages stay in reset.
  - Hold until restart or `i_rstn`.
- Restart
  - `i_restart` high in any state drives all `o_stage_rstn` to 0 and clears `o_done`, `o_error` and `o_err_stage` on the next edge.
  - State goes to HOLD with `k`=0 and counters cleared. In HOLD this restarts the hold count.
- Priority when events coincide: `i_rstn` first, then `i_restart`, then ready, then timeout.
- Counters are sized to the largest parameter value and saturate. Stage index `k` never wraps.

## Timing
- Edge 1 is the first rising edge with `i_rstn` high.
- `o_stage_rstn[0]` is high after edge `HOLD_CYCLES`.
- Ready to next-stage release:
  - ready sampled high at edge r → `o_stage_rstn[k+1]` high after edge r+`STAGE_GAP`;
  - with `STAGE_GAP`=0, after edge r itself.
- Last stage ready sampled at edge r → `o_done` high after edge r.
- Timeout counting:
  - The wait counter starts at 0 on entry to WAIT_RDY.
  - The timeout fires at the edge where the counter has reached `TIMEOUT_CYCLES` with no ready.
  - `o_error` goes high after that edge.
- `i_restart` at edge t → all outputs low after edge t; `o_stage_rstn[0]` high again after edge t+`HOLD_CYCLES`.
- Asserting `i_rstn` low forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- Macro `ACX_RESET_SEQ_TIMEOUT_EN`.
- Defined: the WAIT_RDY timeout counter, the ERROR state, `o_error` and `o_err_stage` are implemented as described above.
- Undefined: WAIT_RDY waits forever, no timeout logic is synthesized, `o_error` is tied to 0 and `o_err_stage` is tied to 0.

## Test plan
- Nominal sequence, `NUM_STAGES`=4, `HOLD_CYCLES`=64, `STAGE_GAP`=16, each ready raised 5 cycles after its release:
  - `o_stage_rstn` steps through 0001, 0011, 0111, 1111;
  - `o_stage_rstn[0]` is high after edge 64, and each subsequent release follows its ready by exactly 16 edges;
  - `o_done`=1 after the last ready.
- `STAGE_GAP`=0 with all ready bits held high from reset:
  - one stage is released per edge after the hold period;
  - `o_done`=1 after edge 64+4.
- Timeout, macro defined, `TIMEOUT_CYCLES`=100, stage 2 ready never asserted:
  - after 100 wait cycles, `o_error`=1, `o_err_stage`=2, `o_stage_rstn`=0011.
  - Then pulse `i_restart`: outputs go to 0000, errors clear, and the sequence reruns.
- Same stimulus with the macro undefined:
  - `o_error` stays 0;
  - the block stays in WAIT_RDY with `o_stage_rstn`=0111 after 1000 cycles.
- `i_restart` pulsed while waiting in GAP after stage 1:
  - `o_stage_rstn`=0000 on the next edge;
  - the hold count restarts, shown by `o_stage_rstn[0]` high again 64 edges later.
- `i_rstn` asserted in DONE:
  - all outputs go to 0 asynchronously;
  - after `i_rstn` is released, the full sequence repeats with identical timing.
